// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage PC sequencer and fetch controller with registered valid/ready output
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned BOOT_DELAY = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic [31:0]          o_imem_addr,
    input  logic [31:0]          i_imem_instr,
    input  logic                 i_redirect_valid,
    input  logic [31:0]          i_redirect_pc,
    input  logic                 i_halt,
    input  logic                 i_dec_ready,
    output logic                 o_fetch_valid,
    output logic [31:0]          o_fetch_pc,
    output logic [31:0]          o_fetch_instr,
    output logic                 o_halted,
    output logic [CNT_WIDTH-1:0] o_fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HELD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int unsigned BOOT_LAST_I = (BOOT_DELAY == 0) ? 0 : BOOT_DELAY - 1;
    localparam logic [3:0]  BOOT_LAST   = BOOT_LAST_I[3:0];
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic [3:0]             boot_cnt_q, boot_cnt_d;
    logic [31:0]            pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [31:0]            fpc_q, fpc_d;
    logic [31:0]            finstr_q, finstr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                   boot_done;
    logic                   run_like;
    logic                   accept;
    logic                   cap;
    logic                   unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    assign boot_done = (BOOT_DELAY == 0) || (boot_cnt_q == BOOT_LAST);
    // HELD behaves as RUN in the cycle ready returns, so no bubble is inserted
    assign run_like  = (state_q == ST_RUN) || ((state_q == ST_HELD) && i_dec_ready);
    assign accept    = valid_q && i_dec_ready;
    assign cap       = run_like && (!valid_q || i_dec_ready) && !i_redirect_valid && !i_halt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                if (!i_redirect_valid && boot_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_HELD: begin
                if (i_redirect_valid) begin
                    state_d = i_halt ? ST_HALTED : ST_RUN;
                end else if (i_halt) begin
                    state_d = ST_HALTED;
                end else if (valid_q && !i_dec_ready) begin
                    state_d = ST_HELD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (i_redirect_valid && !i_halt) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        fpc_d      = fpc_q;
        finstr_d   = finstr_q;
        cnt_d      = cnt_q;

        // A redirect during boot stretches boot by a cycle rather than skipping the exit match
        if ((state_q == ST_BOOT) && !i_redirect_valid && (boot_cnt_q != 4'hF)) begin
            boot_cnt_d = boot_cnt_q + 4'd1;
        end

        if (i_redirect_valid) begin
            pc_d    = {i_redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
        end else if (cap) begin
            fpc_d    = pc_q;
            finstr_d = i_imem_instr;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
        end else if (accept) begin
            valid_d = 1'b0;
        end

        if (accept && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            fpc_q      <= 32'd0;
            finstr_q   <= 32'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            fpc_q      <= fpc_d;
            finstr_q   <= finstr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_imem_addr   = pc_q;
    assign o_fetch_valid = valid_q;
    assign o_fetch_pc    = fpc_q;
    assign o_fetch_instr = finstr_q;
    assign o_halted      = (state_q == ST_HALTED) && !valid_q;
    assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - scoreboard bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_instr = 32'd0;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        i_dec_ready;
    logic        o_fetch_valid;
    logic [31:0] o_fetch_pc;
    logic [31:0] o_fetch_instr;
    logic        o_halted;
    logic [3:0]  o_fetch_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    if_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .BOOT_DELAY (2),
        .CNT_WIDTH  (4)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .o_imem_addr      (o_imem_addr),
        .i_imem_instr     (i_imem_instr),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_halt           (i_halt),
        .i_dec_ready      (i_dec_ready),
        .o_fetch_valid    (o_fetch_valid),
        .o_fetch_pc       (o_fetch_pc),
        .o_fetch_instr    (o_fetch_instr),
        .o_halted         (o_halted),
        .o_fetch_count    (o_fetch_count)
    );

    always #5 i_clk = ~i_clk;

    // addi x1, x0, <word index> at every address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[13:2], 20'h00093};
    endfunction

    always @(negedge i_clk) i_imem_instr <= mem_word(o_imem_addr);

    // A handshake seen at negedge is consumed on the following posedge
    always @(negedge i_clk) begin
        logic [31:0] e;
        if (i_rst_n && o_fetch_valid && i_dec_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL accept_unexpected: got pc=%h instr=%h, required no accept", o_fetch_pc, o_fetch_instr);
            end else begin
                e = exp_q.pop_front();
                if (o_fetch_pc !== e || o_fetch_instr !== mem_word(e)) begin
                    n_err++;
                    $display("FAIL accept_stream: got pc=%h instr=%h, required pc=%h instr=%h",
                             o_fetch_pc, o_fetch_instr, e, mem_word(e));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    initial begin
        i_rst_n = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = 32'd0;
        i_halt = 1'b0; i_dec_ready = 1'b0;
        #2;
        chk("rst_valid", {31'd0, o_fetch_valid}, 32'd0);
        chk("rst_addr", o_imem_addr, 32'd0);
        chk("rst_pc", o_fetch_pc, 32'd0);
        chk("rst_instr", o_fetch_instr, 32'd0);
        chk("rst_halted", {31'd0, o_halted}, 32'd0);
        chk("rst_count", {28'd0, o_fetch_count}, 32'd0);

        // boot and streaming
        @(negedge i_clk); #1;
        i_rst_n = 1'b1; i_dec_ready = 1'b1;
        push_run(32'd0, 2);
        tick(2); chk("boot_valid", {31'd0, o_fetch_valid}, 32'd0);
        tick(1); chk("first_valid", {31'd0, o_fetch_valid}, 32'd1);
        chk("first_pc", o_fetch_pc, 32'd0);
        tick(1); chk("stream_pc4", o_fetch_pc, 32'd4);
        tick(1); i_dec_ready = 1'b0;
        chk("stream_pc8", o_fetch_pc, 32'd8);
        chk("stream_count", {28'd0, o_fetch_count}, 32'd2);

        // back-pressure
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("bp_pc", o_fetch_pc, 32'd8);
            chk("bp_instr", o_fetch_instr, mem_word(32'd8));
            chk("bp_addr", o_imem_addr, 32'd12);
            chk("bp_valid", {31'd0, o_fetch_valid}, 32'd1);
        end
        push_run(32'd8, 2); i_dec_ready = 1'b1;
        tick(1); chk("bp_resume_pc12", o_fetch_pc, 32'd12);
        tick(1); chk("bp_resume_pc16", o_fetch_pc, 32'd16);
        chk("bp_count", {28'd0, o_fetch_count}, 32'd4);

        // redirect flush
        push_run(32'd16, 5);
        tick(5); i_dec_ready = 1'b0;
        chk("pre_rd_pc36", o_fetch_pc, 32'd36);
        chk("pre_rd_count", {28'd0, o_fetch_count}, 32'd9);
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h10;
        tick(1); i_redirect_valid = 1'b0;
        chk("rd_flush_valid", {31'd0, o_fetch_valid}, 32'd0);
        chk("rd_addr", o_imem_addr, 32'h10);
        push_run(32'h10, 1); i_dec_ready = 1'b1;
        tick(1); chk("rd_first_pc", o_fetch_pc, 32'h10);
        chk("rd_count_excl", {28'd0, o_fetch_count}, 32'd9);
        tick(1); i_dec_ready = 1'b0;
        chk("rd_accept_count", {28'd0, o_fetch_count}, 32'd10);
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h13;
        tick(1); i_redirect_valid = 1'b0;
        chk("rd13_addr", o_imem_addr, 32'h10);
        chk("rd13_valid", {31'd0, o_fetch_valid}, 32'd0);
        tick(1); chk("rd13_pc", o_fetch_pc, 32'h10);

        // halt with pending output
        push_run(32'h10, 1); i_dec_ready = 1'b1;
        tick(1); i_dec_ready = 1'b0;
        chk("halt_pre_pc", o_fetch_pc, 32'h14);
        i_halt = 1'b1;
        tick(1);
        chk("halt_hold_valid", {31'd0, o_fetch_valid}, 32'd1);
        chk("halt_hold_pc", o_fetch_pc, 32'h14);
        chk("halt_not_halted", {31'd0, o_halted}, 32'd0);
        chk("halt_addr", o_imem_addr, 32'h18);
        tick(1); chk("halt_hold_pc2", o_fetch_pc, 32'h14);
        push_run(32'h14, 1); i_dec_ready = 1'b1;
        tick(1);
        chk("halt_drain_valid", {31'd0, o_fetch_valid}, 32'd0);
        chk("halted", {31'd0, o_halted}, 32'd1);
        chk("halt_count", {28'd0, o_fetch_count}, 32'd12);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("halt_idle_valid", {31'd0, o_fetch_valid}, 32'd0);
            chk("halt_idle_addr", o_imem_addr, 32'h18);
        end
        i_halt = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = 32'd0;
        tick(1); i_redirect_valid = 1'b0;
        chk("resume_halted", {31'd0, o_halted}, 32'd0);
        chk("resume_addr", o_imem_addr, 32'd0);
        push_run(32'd0, 2);
        tick(3); i_dec_ready = 1'b0;
        chk("resume_pc8", o_fetch_pc, 32'd8);
        chk("resume_count", {28'd0, o_fetch_count}, 32'd14);

        // simultaneous redirect and halt
        i_redirect_valid = 1'b1; i_halt = 1'b1; i_redirect_pc = 32'h40;
        tick(1); i_redirect_valid = 1'b0;
        chk("rdh_addr", o_imem_addr, 32'h40);
        chk("rdh_valid", {31'd0, o_fetch_valid}, 32'd0);
        chk("rdh_halted", {31'd0, o_halted}, 32'd1);
        tick(2);
        chk("rdh_stay_halted", {31'd0, o_halted}, 32'd1);
        chk("rdh_stay_addr", o_imem_addr, 32'h40);

        // PC wrap and counter saturation
        i_halt = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFC; i_dec_ready = 1'b1;
        tick(1); i_redirect_valid = 1'b0;
        chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        tick(1);
        chk("wrap_pc", o_fetch_pc, 32'hFFFF_FFFC);
        chk("wrap_next_addr", o_imem_addr, 32'd0);
        push_run(32'd0, 8);
        tick(1);
        chk("wrap_pc0", o_fetch_pc, 32'd0);
        chk("sat_count_15", {28'd0, o_fetch_count}, 32'd15);
        tick(8); i_dec_ready = 1'b0;
        chk("sat_pc32", o_fetch_pc, 32'd32);
        chk("sat_count_hold", {28'd0, o_fetch_count}, 32'd15);

        // async reset between edges
        #2; i_rst_n = 1'b0; #1;
        chk("arst_valid", {31'd0, o_fetch_valid}, 32'd0);
        chk("arst_addr", o_imem_addr, 32'd0);
        chk("arst_pc", o_fetch_pc, 32'd0);
        chk("arst_count", {28'd0, o_fetch_count}, 32'd0);
        @(negedge i_clk); #1;
        i_rst_n = 1'b1; i_dec_ready = 1'b1;
        push_run(32'd0, 2);
        tick(2); chk("reboot_valid", {31'd0, o_fetch_valid}, 32'd0);
        tick(1); chk("reboot_first_pc", o_fetch_pc, 32'd0);
        chk("reboot_first_valid", {31'd0, o_fetch_valid}, 32'd1);
        tick(2); i_dec_ready = 1'b0;
        chk("reboot_pc8", o_fetch_pc, 32'd8);
        chk("reboot_count", {28'd0, o_fetch_count}, 32'd2);

        tick(2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
